spi_controller: RTL and testbench

SPI controller (initiator) for the register-access SPI target used across our designs: it turns a parallel single-register request into one framed SPI transaction, either writing a config register or reading a status register. It serves as the bench/host-side counterpart for chip-level tests and as a bridge in designs that chain register blocks on-chip. All SPI outputs are registered in the `clk` domain.

---
 rtl/spi_controller_if.sv | 25 ++
 rtl/spi_controller.sv | 156 +++++++++++++++
 tb/tb_spi_controller.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_controller_if.sv
// Parallel request/response bus between a host and spi_controller.
// The host drives the request fields; the controller returns status and read data.
interface spi_controller_if #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [1:0]            mode;
  logic                  start;
  logic                  rw;
  logic [ADDR_WIDTH-1:0] addr;
  logic [REG_WIDTH-1:0]  wdata;
  logic                  busy;
  logic                  done;
  logic [REG_WIDTH-1:0]  rdata;

  modport master (
    output mode, start, rw, addr, wdata,
    input  busy, done, rdata
  );

  modport slave (
    input  mode, start, rw, addr, wdata,
    output busy, done, rdata
  );
endinterface

// File: rtl/spi_controller.sv
// SPI initiator: turns one register request into a framed SPI transaction
// (command byte + data field, MSB first), all SPI outputs registered.
module spi_controller #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int CLK_DIV    = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  spi_controller_if.slave   bus,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int NBITS  = 8 + REG_WIDTH;
  localparam int NEDGES = 2 * NBITS;
  localparam int CW     = $clog2(CLK_DIV + 1);
  localparam int EW     = $clog2(NEDGES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t               state_reg;
  logic [CW-1:0]        cnt_reg;
  logic [EW-1:0]        edge_cnt_reg;
  logic [NBITS-1:0]     tx_reg;
  logic [REG_WIDTH-1:0] rx_reg;
  logic                 rw_reg;
  logic                 cpha_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 cs_n_reg;
  logic                 sclk_reg;
  logic                 mosi_reg;
  logic [REG_WIDTH-1:0] rdata_reg;

  logic [7:0]           cmd_byte;
  logic [NBITS-1:0]     frame;
  logic                 cnt_last;
  logic                 edge_now;
  logic                 leading;
  logic                 final_edge;

  always_comb begin
    cmd_byte                   = '0;
    cmd_byte[7]                = bus.rw;
    cmd_byte[ADDR_WIDTH-1:0]   = bus.addr;
    frame = {cmd_byte, bus.rw ? bus.wdata : {REG_WIDTH{1'b0}}};
  end

  // edge_cnt_reg counts edges already produced, so an even count means the
  // next edge is a leading one.
  assign cnt_last   = (cnt_reg == CW'(CLK_DIV - 1));
  assign leading    = ~edge_cnt_reg[0];
  assign final_edge = (edge_cnt_reg == EW'(NEDGES - 1));
  assign edge_now   = cnt_last &&
                      ((state_reg == SETUP) ||
                       (state_reg == SHIFT && edge_cnt_reg != EW'(NEDGES)));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      edge_cnt_reg <= '0;
      tx_reg       <= '0;
      rx_reg       <= '0;
      rw_reg       <= 1'b0;
      cpha_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      cs_n_reg     <= 1'b1;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      rdata_reg    <= '0;
    end else if (ena) begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          sclk_reg     <= bus.mode[1];
          cnt_reg      <= '0;
          edge_cnt_reg <= '0;
          if (bus.start) begin
            state_reg <= SETUP;
            cs_n_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            rw_reg    <= bus.rw;
            cpha_reg  <= bus.mode[0];
            // CPHA=0 presents the MSB now, so the shifter starts one bit ahead.
            tx_reg    <= bus.mode[0] ? frame : {frame[NBITS-2:0], 1'b0};
            mosi_reg  <= bus.mode[0] ? 1'b0 : frame[NBITS-1];
          end
        end
        SETUP: begin
          if (cnt_last) begin
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt_last) begin
            cnt_reg <= '0;
            if (edge_cnt_reg == EW'(NEDGES)) state_reg <= HOLD;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HOLD: begin
          if (cnt_last) begin
            cnt_reg   <= '0;
            state_reg <= GAP;
            cs_n_reg  <= 1'b1;
            done_reg  <= 1'b1;
            if (!rw_reg) rdata_reg <= rx_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        GAP: begin
          if (cnt_last) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Only the last REG_WIDTH sampled bits survive, which drops the
      // command-phase MISO bits automatically.
      if (edge_now) begin
        sclk_reg     <= ~sclk_reg;
        edge_cnt_reg <= edge_cnt_reg + 1'b1;
        if (leading ^ cpha_reg) begin
          rx_reg <= {rx_reg[REG_WIDTH-2:0], spi_miso};
        end else if (cpha_reg || !final_edge) begin
          mosi_reg <= tx_reg[NBITS-1];
          tx_reg   <= {tx_reg[NBITS-2:0], 1'b0};
        end
      end
    end
  end

  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
  assign bus.rdata = rdata_reg;
  assign spi_cs_n  = cs_n_reg;
  assign spi_clk   = sclk_reg;
  assign spi_mosi  = mosi_reg;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: a behavioural SPI target plus
// directed and randomized register transactions checked against frame rules.
module tb_spi_controller;

  localparam int RW       = 8;
  localparam int AW       = 3;
  localparam int D        = 4;
  localparam int NB       = 8 + RW;
  localparam int CS_LOW   = D * (2 + 2 * NB);
  localparam int DONE_LAT = CS_LOW + 1;
  localparam int BUSY_LAT = D * (3 + 2 * NB) + 1;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  logic ena  = 1'b0;
  logic spi_cs_n, spi_clk, spi_mosi;
  logic spi_miso = 1'b0;

  spi_controller_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) ifc ();

  spi_controller #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .CLK_DIV(D)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .bus      (ifc),
    .spi_cs_n (spi_cs_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Target configuration, written only by the stimulus process.
  logic          cpol_t = 1'b0;
  logic          cpha_t = 1'b0;
  logic [NB-1:0] tgt_frame = '0;

  // Target / monitor state, written only by the monitor process.
  logic          prev_cs = 1'b1;
  logic          prev_sclk = 1'b0;
  int            cs_low_cnt = 0;
  int            edges = 0;
  int            launched = 0;
  int            done_cnt = 0;
  logic [NB-1:0] rx_bits = '0;
  logic          idle_before = 1'b0;
  logic          idle_after = 1'b0;

  logic [RW-1:0] exp_rdata = '0;

  // Behavioural SPI target sampled mid-cycle: launches MISO on its launch
  // edges, captures MOSI on its sample edges, and measures the frame.
  always @(negedge clk) begin
    prev_cs   <= spi_cs_n;
    prev_sclk <= spi_clk;
    if (prev_cs && !spi_cs_n) begin
      cs_low_cnt  <= 1;
      edges       <= 0;
      rx_bits     <= '0;
      idle_before <= spi_clk;
      if (!cpha_t) begin
        spi_miso <= tgt_frame[NB-1];
        launched <= 1;
      end else begin
        launched <= 0;
      end
    end else if (!spi_cs_n) begin
      cs_low_cnt <= cs_low_cnt + 1;
      if (spi_clk != prev_sclk) begin
        edges <= edges + 1;
        if ((prev_sclk == cpol_t) ^ cpha_t) begin
          rx_bits <= {rx_bits[NB-2:0], spi_mosi};
        end else if (launched < NB) begin
          spi_miso <= tgt_frame[NB-1-launched];
          launched <= launched + 1;
        end
      end
    end
    if (!prev_cs && spi_cs_n) idle_after <= spi_clk;
    if (ifc.done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input string tag, input logic rw_i, input logic [AW-1:0] addr_i,
                           input logic [RW-1:0] wdata_i, input logic [RW-1:0] tdata_i,
                           input logic [1:0] mode_i, input int stall, input bit pulse);
    int            cyc;
    int            d0;
    int            snap_edges;
    bit            stalled;
    logic [2:0]    snap;
    logic [NB-1:0] exp_bits;
    exp_bits = NB'((int'(rw_i) * 128 + int'(addr_i)) * (1 << RW) + (rw_i ? int'(wdata_i) : 0));
    @(negedge clk);
    ifc.mode  = mode_i;
    ifc.rw    = rw_i;
    ifc.addr  = addr_i;
    ifc.wdata = wdata_i;
    cpol_t    = mode_i[1];
    cpha_t    = mode_i[0];
    tgt_frame = {8'($urandom), tdata_i};
    repeat (2) @(negedge clk);
    d0        = done_cnt;
    ifc.start = 1'b1;
    cyc       = 0;
    stalled   = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      ifc.start = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      if (ifc.done) break;
      if (cyc > 4 * BUSY_LAT) begin
        chk({tag, " done timeout"}, {31'd0, ifc.done}, 32'd1);
        ifc.start = 1'b0;
        return;
      end
      if (stall > 0 && !stalled && cyc > 4 && edges >= 10) begin
        snap       = {spi_cs_n, spi_clk, spi_mosi};
        snap_edges = edges;
        ena        = 1'b0;
        repeat (stall) @(negedge clk);
        cyc += stall;
        chk({tag, " stall outputs"}, {29'd0, spi_cs_n, spi_clk, spi_mosi}, {29'd0, snap});
        chk({tag, " stall edges"}, edges, snap_edges);
        ena     = 1'b1;
        stalled = 1'b1;
      end
    end
    ifc.start = 1'b0;
    if (!rw_i) exp_rdata = tdata_i;
    chk({tag, " done latency"}, cyc, DONE_LAT + stall);
    chk({tag, " rdata"}, ifc.rdata, exp_rdata);
    chk({tag, " cs high at done"}, {31'd0, spi_cs_n}, 32'd1);
    while (ifc.busy) begin
      @(negedge clk);
      cyc++;
      if (cyc > 4 * BUSY_LAT) begin
        chk({tag, " busy timeout"}, {31'd0, ifc.busy}, 32'd0);
        return;
      end
    end
    chk({tag, " busy latency"}, cyc, BUSY_LAT + stall);
    chk({tag, " cs low cycles"}, cs_low_cnt, CS_LOW + stall);
    chk({tag, " sclk edges"}, edges, 2 * NB);
    chk({tag, " mosi frame"}, rx_bits, exp_bits);
    chk({tag, " idle before"}, {31'd0, idle_before}, {31'd0, mode_i[1]});
    chk({tag, " idle after"}, {31'd0, idle_after}, {31'd0, mode_i[1]});
    chk({tag, " done pulses"}, done_cnt - d0, 1);
    if (pulse) begin
      repeat (3) @(negedge clk);
      chk({tag, " no queued frame"}, {31'd0, spi_cs_n}, 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            t;
    int            d0;
    logic [RW-1:0] td;
    ifc.mode  = 2'b00;
    ifc.start = 1'b0;
    ifc.rw    = 1'b0;
    ifc.addr  = '0;
    ifc.wdata = '0;

    // Reset held with random inputs
    repeat (8) begin
      @(negedge clk);
      ena       = 1'($urandom);
      ifc.start = 1'($urandom);
      ifc.mode  = 2'($urandom);
      ifc.rw    = 1'($urandom);
      ifc.addr  = AW'($urandom);
      ifc.wdata = RW'($urandom);
    end
    chk("reset cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("reset sclk", {31'd0, spi_clk}, 32'd0);
    chk("reset mosi", {31'd0, spi_mosi}, 32'd0);
    chk("reset busy", {31'd0, ifc.busy}, 32'd0);
    chk("reset done", {31'd0, ifc.done}, 32'd0);
    chk("reset rdata", ifc.rdata, 32'd0);
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.mode  = 2'b00;
    ena       = 1'b1;
    rstb      = 1'b1;
    repeat (2) @(negedge clk);

    // Directed write and reads in every mode
    run_frame("wr m0", 1'b1, 3'd2, 8'h35, 8'h00, 2'd0, 0, 1'b0);
    for (int m = 0; m < 4; m++)
      run_frame($sformatf("rd m%0d", m), 1'b0, 3'd4, 8'h00, 8'hC4, 2'(m), 0, 1'b0);

    // Randomized transactions
    for (int i = 0; i < 4; i++)
      run_frame($sformatf("rand%0d", i), 1'($urandom), AW'($urandom), RW'($urandom),
                RW'($urandom), 2'($urandom), 0, 1'b0);

    // Start pulsed repeatedly while busy
    run_frame("pulse", 1'b0, 3'd6, 8'h00, RW'($urandom), 2'd1, 0, 1'b1);

    // Start held high across two frames
    td = RW'($urandom);
    @(negedge clk);
    ifc.mode  = 2'd0;
    ifc.rw    = 1'b0;
    ifc.addr  = 3'd3;
    cpol_t    = 1'b0;
    cpha_t    = 1'b0;
    tgt_frame = {8'h00, td};
    @(negedge clk);
    d0        = done_cnt;
    ifc.start = 1'b1;
    t = 0;
    while (!ifc.busy && t < 10) begin @(negedge clk); t++; end
    t = 0;
    while (ifc.busy && t < 2 * BUSY_LAT) begin @(negedge clk); t++; end
    chk("held busy drop", {31'd0, ifc.busy}, 32'd0);
    @(negedge clk);
    chk("held next cs", {31'd0, spi_cs_n}, 32'd0);
    chk("held next busy", {31'd0, ifc.busy}, 32'd1);
    ifc.start = 1'b0;
    t = 0;
    while (ifc.busy && t < 2 * BUSY_LAT) begin @(negedge clk); t++; end
    exp_rdata = td;
    chk("held done count", done_cnt - d0, 2);
    chk("held rdata", ifc.rdata, exp_rdata);

    // Reset in the middle of a frame
    @(negedge clk);
    ifc.mode  = 2'd0;
    ifc.rw    = 1'b1;
    ifc.addr  = 3'd5;
    ifc.wdata = RW'($urandom);
    cpol_t    = 1'b0;
    cpha_t    = 1'b0;
    @(negedge clk);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (2) @(negedge clk);
    t = 0;
    while (edges != 5 && t < 100) begin @(negedge clk); t++; end
    chk("midrst sclk before", {31'd0, spi_clk}, 32'd1);
    #2 rstb = 1'b0;
    #1;
    exp_rdata = '0;
    chk("midrst cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("midrst sclk", {31'd0, spi_clk}, 32'd0);
    chk("midrst mosi", {31'd0, spi_mosi}, 32'd0);
    chk("midrst busy", {31'd0, ifc.busy}, 32'd0);
    chk("midrst rdata", ifc.rdata, exp_rdata);
    @(negedge clk);
    rstb = 1'b1;
    run_frame("after rst", 1'b1, 3'd1, 8'h5A, 8'h00, 2'd0, 0, 1'b0);

    // Enable stall during SHIFT
    run_frame("stall", 1'b0, 3'd7, 8'h00, RW'($urandom), 2'($urandom), 10, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
